// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus responder: FSM states, access
// size codes, request channel IDs and lane-steering helpers.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_RESP,
    ST_WR,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    CH_NONE   = 2'd0,
    CH_IREAD  = 2'd1,
    CH_DREAD  = 2'd2,
    CH_DWRITE = 2'd3
  } chan_e;

  // w wins over hw, so w=hw=1 degrades to a word access
  function automatic size_e size_code(input logic w, input logic hw);
    if (w)       return SZ_WORD;
    else if (hw) return SZ_HALF;
    else         return SZ_BYTE;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return (lo != 2'b00);
      SZ_HALF: return lo[0];
      default: return 1'b0;
    endcase
  endfunction

  // Force the low address bits onto the natural boundary of the access
  function automatic logic [1:0] align_lo(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return 2'b00;
      SZ_HALF: return {lo[1], 1'b0};
      default: return lo;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << lo;
    endcase
  endfunction

  // Right-aligned write data copied into every lane the access could hit
  function automatic logic [31:0] replicate(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_WORD: return d;
      SZ_HALF: return {2{d[15:0]}};
      default: return {4{d[7:0]}};
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input size_e sz);
    case (sz)
      SZ_WORD: return 32'hFFFF_FFFF;
      SZ_HALF: return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_responder_sram.sv
// Word-organised single-port RAM with per-byte write enables and a
// registered read port; written so synthesis maps it onto block RAM.
module bus_sram #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**MEM_AW];
  logic [31:0] rdata_q;

  // Byte-lane writes and read-before-write output register
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Arbitrates the CPU's instruction-read, data-read and data-write channels
// and serves one access at a time from the local SRAM.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  input  logic        d_read_req,
  input  logic        d_read_w,
  input  logic        d_read_hw,
  input  logic [31:0] d_read_adr,
  input  logic        d_write_req,
  input  logic        d_write_w,
  input  logic        d_write_hw,
  input  logic [31:0] d_write_adr,
  input  logic [31:0] d_write_data,
  output logic        read_valid,
  output logic [31:0] read_data,
  output logic        write_finish,
  output logic        bus_err
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               read_valid_q, read_valid_d;
  logic               write_finish_q, write_finish_d;
  logic               bus_err_q, bus_err_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [MEM_AW+1:0]  adr_q, adr_d;
  size_e              size_q, size_d;
  logic [31:0]        wdata_q, wdata_d;

  chan_e              g_chan;
  logic               g_w, g_hw;
  logic [31:0]        g_adr;
  size_e              g_size;

  logic               sram_en;
  logic [3:0]         sram_we;
  logic [31:0]        sram_rdata;
  logic [31:0]        steered;

  // Address bits above the SRAM size are ignored so accesses wrap
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_read_adr[31:MEM_AW+2], d_read_adr[31:MEM_AW+2],
                             d_write_adr[31:MEM_AW+2]};

  // Fixed-priority pick of the pending channel: write, data read, instr read
  always_comb begin
    g_chan = CH_NONE;
    g_w    = 1'b0;
    g_hw   = 1'b0;
    g_adr  = '0;
    if (d_write_req) begin
      g_chan = CH_DWRITE; g_w = d_write_w; g_hw = d_write_hw; g_adr = d_write_adr;
    end else if (d_read_req) begin
      g_chan = CH_DREAD;  g_w = d_read_w;  g_hw = d_read_hw;  g_adr = d_read_adr;
    end else if (i_read_req) begin
      g_chan = CH_IREAD;  g_w = i_read_w;  g_hw = i_read_hw;  g_adr = i_read_adr;
    end
    g_size = size_code(g_w, g_hw);
  end

  // Selected SRAM lane moved down to bit 0 and zero-extended
  assign steered = (sram_rdata >> {adr_q[1:0], 3'b000}) & lane_mask(size_q);

  // SRAM is only touched in RD/WR so a reset during WR never commits a write
  assign sram_en = (state_q == ST_RD) || (state_q == ST_WR);
  assign sram_we = (state_q == ST_WR) ? byte_en(size_q, adr_q[1:0]) : 4'b0000;

  bus_sram #(.MEM_AW(MEM_AW)) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (adr_q[MEM_AW+1:2]),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  // Next-state, countdown and completion-pulse logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    adr_d          = adr_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    read_valid_d   = 1'b0;
    write_finish_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (g_chan != CH_NONE) begin
          size_d  = g_size;
          err_d   = (g_w & g_hw) | misaligned(g_size, g_adr[1:0]);
          adr_d   = {g_adr[MEM_AW+1:2], align_lo(g_size, g_adr[1:0])};
          wdata_d = replicate(g_size, d_write_data);
          state_d = (g_chan == CH_DWRITE) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (RD_WAIT == 0) begin
          state_d      = ST_RESP;
          read_valid_d = 1'b1;
        end else begin
          state_d = ST_RD_WAIT;
          cnt_d   = 4'(RD_WAIT - 1);
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          read_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_DONE;
      ST_WR: begin
        state_d        = ST_WR_WAIT;
        cnt_d          = 4'(WR_WAIT);
        write_finish_d = (WR_WAIT == 0);
      end
      ST_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d          = cnt_q - 4'd1;
          write_finish_d = (cnt_q == 4'd1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    bus_err_d   = err_d & (read_valid_d | write_finish_d);
    read_data_d = read_data;
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      err_q          <= 1'b0;
      read_valid_q   <= 1'b0;
      write_finish_q <= 1'b0;
      bus_err_q      <= 1'b0;
      read_data_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      read_valid_q   <= read_valid_d;
      write_finish_q <= write_finish_d;
      bus_err_q      <= bus_err_d;
      read_data_q    <= read_data_d;
    end
  end

  // Latched request payload; only meaningful while a transaction is active
  always_ff @(posedge clk) begin
    adr_q   <= adr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end

  assign read_valid   = read_valid_q;
  assign write_finish = write_finish_q;
  assign bus_err      = bus_err_q;
  // SRAM output is steered live during the pulse and held afterwards
  assign read_data    = read_valid_q ? steered : read_data_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: two instances (zero-wait and waited), directed
// vector table, multi-cycle corner sequences and randomized model checking.
module tb_cpu_bus_responder;

  localparam int AW_A = 12;
  localparam int AW_B = 8;
  localparam int RDW_B = 3;
  localparam int WRW_B = 2;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic i_read_req, i_read_w, i_read_hw;
  logic [31:0] i_read_adr;
  logic d_read_req, d_read_w, d_read_hw;
  logic [31:0] d_read_adr;
  logic d_write_req, d_write_w, d_write_hw;
  logic [31:0] d_write_adr, d_write_data;

  logic a_irq, a_drq, a_dwq, b_irq, b_drq, b_dwq;
  logic a_rv, a_wf, a_be, b_rv, b_wf, b_be;
  logic [31:0] a_rd, b_rd;
  logic rv, wf, be;
  logic [31:0] rd;

  assign a_irq = i_read_req  & ~sel;
  assign a_drq = d_read_req  & ~sel;
  assign a_dwq = d_write_req & ~sel;
  assign b_irq = i_read_req  & sel;
  assign b_drq = d_read_req  & sel;
  assign b_dwq = d_write_req & sel;
  assign rv = sel ? b_rv : a_rv;
  assign wf = sel ? b_wf : a_wf;
  assign be = sel ? b_be : a_be;
  assign rd = sel ? b_rd : a_rd;

  cpu_bus_responder #(.MEM_AW(AW_A), .RD_WAIT(0), .WR_WAIT(0)) dut_a (
    .clk(clk), .rst(rst),
    .i_read_req(a_irq), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
    .d_read_req(a_drq), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
    .d_write_req(a_dwq), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
    .d_write_adr(d_write_adr), .d_write_data(d_write_data),
    .read_valid(a_rv), .read_data(a_rd), .write_finish(a_wf), .bus_err(a_be)
  );

  cpu_bus_responder #(.MEM_AW(AW_B), .RD_WAIT(RDW_B), .WR_WAIT(WRW_B)) dut_b (
    .clk(clk), .rst(rst),
    .i_read_req(b_irq), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
    .d_read_req(b_drq), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
    .d_write_req(b_dwq), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
    .d_write_adr(d_write_adr), .d_write_data(d_write_data),
    .read_valid(b_rv), .read_data(b_rd), .write_finish(b_wf), .bus_err(b_be)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed memory model: spec-level view of the SRAM
  logic [7:0] mdl [int unsigned];

  function automatic int unsigned nbytes(input logic w, input logic hw);
    return w ? 4 : (hw ? 2 : 1);
  endfunction

  function automatic logic model_err(input logic [31:0] adr, input logic w, input logic hw);
    return (w && hw) || ((adr % nbytes(w, hw)) != 0);
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic w, input logic hw,
                             input logic [31:0] data, input int aw);
    int unsigned n = nbytes(w, hw);
    int unsigned base = adr - (adr % n);
    int unsigned mb = 4 << aw;
    for (int i = 0; i < int'(n); i++) mdl[(base + i) % mb] = data[i*8 +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr, input logic w,
                                             input logic hw, input int aw);
    int unsigned n = nbytes(w, hw);
    int unsigned base = adr - (adr % n);
    int unsigned mb = 4 << aw;
    logic [31:0] r = 32'd0;
    for (int i = 0; i < int'(n); i++) r = r | ({24'd0, mdl[(base + i) % mb]} << (8 * i));
    return r;
  endfunction

  task automatic idle_inputs();
    i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = 0;
    d_read_req = 0; d_read_w = 0; d_read_hw = 0; d_read_adr = 0;
    d_write_req = 0; d_write_w = 0; d_write_hw = 0; d_write_adr = 0; d_write_data = 0;
  endtask

  // kind: 0 instr read, 1 data read, 2 data write. Called at a negedge with DUT idle.
  task automatic run_txn(input int kind, input logic w, input logic hw,
                         input logic [31:0] adr, input logic [31:0] data,
                         output int lat, output logic [31:0] rdat,
                         output logic err, output int wrong);
    lat = -1; rdat = 32'hx; err = 1'bx; wrong = 0;
    case (kind)
      0: begin i_read_req = 1; i_read_w = w; i_read_hw = hw; i_read_adr = adr; end
      1: begin d_read_req = 1; d_read_w = w; d_read_hw = hw; d_read_adr = adr; end
      default: begin
        d_write_req = 1; d_write_w = w; d_write_hw = hw; d_write_adr = adr; d_write_data = data;
      end
    endcase
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if ((kind == 2) ? rv : wf) wrong++;
      if ((kind == 2) ? wf : rv) begin
        lat = c; rdat = rd; err = be;
        break;
      end
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  typedef struct {
    int          kind;
    logic        w;
    logic        hw;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic random_phase(input int aw, input int rdw, input int wrw, input int n);
    int lat, wrong;
    logic [31:0] rdat, d, adr, exp;
    logic err, w, hw;
    int kind, sz;
    mdl.delete();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      run_txn(2, 1'b1, 1'b0, 32'(k * 4), d, lat, rdat, err, wrong);
      model_write(32'(k * 4), 1'b1, 1'b0, d, aw);
      check($sformatf("init%0d_lat", k), 32'(lat), 32'(2 + wrw));
    end
    for (int t = 0; t < n; t++) begin
      kind = $urandom_range(0, 2);
      sz = $urandom_range(0, 3);
      w = sz[1]; hw = sz[0];
      adr = $urandom_range(0, 63) + $urandom_range(0, 3) * (4 << aw);
      d = $urandom;
      run_txn(kind, w, hw, adr, d, lat, rdat, err, wrong);
      check($sformatf("rnd%0d_lat k%0d a%h", t, kind, adr), 32'(lat),
            32'((kind == 2) ? 2 + wrw : 2 + rdw));
      check($sformatf("rnd%0d_err a%h w%0d hw%0d", t, adr, w, hw), {31'd0, err},
            {31'd0, model_err(adr, w, hw)});
      if (kind == 2) begin
        model_write(adr, w, hw, d, aw);
      end else begin
        exp = model_read(adr, w, hw, aw);
        check($sformatf("rnd%0d_data a%h w%0d hw%0d", t, adr, w, hw), rdat, exp);
      end
    end
  endtask

  initial begin
    int lat, wrong, np, nreads;
    logic [31:0] rdat;
    logic err;
    int pcyc[3];
    logic [31:0] pdat[3];
    logic pwr[3];

    sel = 0;
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_outputs", {rv, wf, be}, 32'd0);
    check("reset_read_data", rd, 32'd0);

    // Directed table for the zero-wait instance (kind: 0 iread, 1 dread, 2 write)
    vecs.push_back('{2, 1'b1, 1'b0, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{2, 1'b1, 1'b0, 32'h100,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{2, 1'b0, 1'b0, 32'h103,  32'h000000A5, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h100,  32'h0,        32'hA5223344, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b0, 32'h103,  32'h0,        32'h000000A5, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h102,  32'h0,        32'h0000A522, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h101,  32'h0,        32'h00003344, 1'b1});
    vecs.push_back('{2, 1'b1, 1'b1, 32'h104,  32'hCAFEF00D, 32'h0,        1'b1});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h104,  32'h0,        32'hCAFEF00D, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h106,  32'h0,        32'hCAFEF00D, 1'b1});
    vecs.push_back('{2, 1'b0, 1'b1, 32'h106,  32'h0000BEEF, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h104,  32'h0,        32'hBEEFF00D, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b0, 32'h105,  32'h0,        32'h000000F0, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h4100, 32'h0,        32'hA5223344, 1'b0});
    vecs.push_back('{2, 1'b0, 1'b0, 32'h4107, 32'h00000012, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h104,  32'h0,        32'h12EFF00D, 1'b0});
    vecs.push_back('{2, 1'b1, 1'b0, 32'h200,  32'h00000000, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b0, 1'b1, 32'h203,  32'h0,        32'h00000000, 1'b1});

    foreach (vecs[i]) begin
      run_txn(vecs[i].kind, vecs[i].w, vecs[i].hw, vecs[i].adr, vecs[i].data,
              lat, rdat, err, wrong);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_wrong_pulse", i), 32'(wrong), 32'd0);
      if (vecs[i].kind != 2) check($sformatf("vec%0d_data", i), rdat, vecs[i].exp);
    end

    // All three channels at once: write, then data read, then instr read
    d_write_req = 1; d_write_w = 1; d_write_adr = 32'h300; d_write_data = 32'h55AA55AA;
    d_read_req  = 1; d_read_w  = 1; d_read_adr  = 32'h104;
    i_read_req  = 1; i_read_w  = 1; i_read_adr  = 32'h100;
    np = 0; nreads = 0;
    for (int k = 0; k < 3; k++) begin pcyc[k] = 0; pdat[k] = 0; pwr[k] = 0; end
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (wf || rv) begin
        if (np < 3) begin pcyc[np] = c; pwr[np] = wf; pdat[np] = rd; end
        np++;
        if (wf) d_write_req = 0;
        else if (nreads == 0) begin d_read_req = 0; nreads++; end
        else i_read_req = 0;
      end
    end
    idle_inputs();
    check("prio_pulse_count", 32'(np), 32'd3);
    check("prio_first_is_write", {31'd0, pwr[0]}, 32'd1);
    check("prio_first_cycle", 32'(pcyc[0]), 32'd2);
    check("prio_second_is_read", {31'd0, pwr[1]}, 32'd0);
    check("prio_second_data", pdat[1], 32'h12EFF00D);
    check("prio_second_cycle", 32'(pcyc[1]), 32'd6);
    check("prio_third_is_read", {31'd0, pwr[2]}, 32'd0);
    check("prio_third_data", pdat[2], 32'hA5223344);
    check("prio_third_cycle", 32'(pcyc[2]), 32'd10);
    check("hold_read_data", rd, 32'hA5223344);

    // Reset while a write to 0x200 sits in WR
    d_write_req = 1; d_write_w = 1; d_write_adr = 32'h200; d_write_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("rst_mid_outputs", {rv, wf, be}, 32'd0);
    check("rst_mid_read_data", rd, 32'd0);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(negedge clk);
    run_txn(1, 1'b1, 1'b0, 32'h200, 32'h0, lat, rdat, err, wrong);
    check("rst_mid_readback", rdat, 32'h00000000);
    check("rst_mid_readback_lat", 32'(lat), 32'd2);

    // Waited instance: RD_WAIT=3, WR_WAIT=2, 1 KB memory
    sel = 1;
    do_reset();
    check("b_read_data_before_read", rd, 32'd0);
    run_txn(2, 1'b1, 1'b0, 32'h10, 32'h12345678, lat, rdat, err, wrong);
    check("b_write_lat", 32'(lat), 32'd4);
    run_txn(1, 1'b1, 1'b0, 32'h10, 32'h0, lat, rdat, err, wrong);
    check("b_read_lat", 32'(lat), 32'd5);
    check("b_read_data", rdat, 32'h12345678);
    run_txn(0, 1'b1, 1'b0, 32'h410, 32'h0, lat, rdat, err, wrong);
    check("b_wrap_data", rdat, 32'h12345678);
    run_txn(1, 1'b0, 1'b1, 32'h13, 32'h0, lat, rdat, err, wrong);
    check("b_mis_half_data", rdat, 32'h00001234);
    check("b_mis_half_err", {31'd0, err}, 32'd1);

    // Randomized traffic on both instances against the byte model
    sel = 0;
    random_phase(AW_A, 0, 0, 150);
    sel = 1;
    random_phase(AW_B, RDW_B, WRW_B, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
